// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time trial controller.
package reaction_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    TIMING = 3'd2,
    DONE   = 3'd3,
    CHEAT  = 3'd4
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 mapped onto bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_ctrl_tick_gen.sv
// Single-cycle tick enable every CLKFREQ/TICKFREQ clocks, with synchronous clear.
module tick_gen #(
  parameter int unsigned CLKFREQ  = 100_000_000,
  parameter int unsigned TICKFREQ = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int unsigned TICKDIV = CLKFREQ / TICKFREQ;
  localparam int unsigned CW      = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(TICKDIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + CW'(1);
  end

endmodule

// File: rtl/reaction_ctrl.sv
// Sequences one reaction-time trial: random pre-delay, stimulus LED, ms timing.
module reaction_ctrl
  import reaction_pkg::*;
#(
  parameter int unsigned CLKFREQ         = 100_000_000,
  parameter int unsigned TICKFREQ        = 1000,
  parameter int unsigned MAXMS           = 9999,
  parameter int unsigned DELAY_MIN       = 1000,
  parameter int unsigned DELAY_RAND_BITS = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  output logic                         led,
  output logic [$clog2(MAXMS+1)-1:0]   time_ms,
  output logic                         valid,
  output logic                         timeout,
  output logic                         cheat,
  output logic [2:0]                   state
);

  localparam int unsigned TW = $clog2(MAXMS + 1);
  localparam int unsigned DW = $clog2(DELAY_MIN + 2**DELAY_RAND_BITS);
  localparam logic [15:0] RAND_MASK = 16'((17'd1 << DELAY_RAND_BITS) - 17'd1);

  state_t        r_state;
  logic [15:0]   r_lfsr;
  logic [DW-1:0] r_delay;
  logic [TW-1:0] r_time;
  logic          r_led;
  logic          r_valid;
  logic          r_timeout;
  logic          r_cheat;

  logic          w_tick;
  logic          w_clr;
  logic [15:0]   w_rand;
  logic [DW-1:0] w_delay_init;

  assign w_rand       = r_lfsr & RAND_MASK;
  assign w_delay_init = DW'(DELAY_MIN) + DW'(w_rand);

  // Restart the tick phase on every edge entering WAIT or TIMING.
  always_comb begin
    w_clr = 1'b0;
    case (r_state)
      IDLE, DONE, CHEAT: w_clr = start;
      WAIT:              w_clr = !stop && w_tick && (r_delay == DW'(1));
      default:           w_clr = 1'b0;
    endcase
  end

  tick_gen #(
    .CLKFREQ (CLKFREQ),
    .TICKFREQ(TICKFREQ)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (w_clr),
    .tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= lfsr_next(r_lfsr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_delay   <= '0;
      r_time    <= '0;
      r_led     <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_cheat   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE, CHEAT: begin
          if (start) begin
            r_state   <= WAIT;
            r_delay   <= w_delay_init;
            r_time    <= '0;
            r_led     <= 1'b0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_cheat   <= 1'b0;
          end
        end
        WAIT: begin
          if (stop) begin
            r_state <= CHEAT;
            r_cheat <= 1'b1;
            r_time  <= '0;
            r_led   <= 1'b0;
          end else if (w_tick) begin
            if (r_delay == DW'(1)) begin
              r_state <= TIMING;
              r_led   <= 1'b1;
            end
            r_delay <= r_delay - DW'(1);
          end
        end
        TIMING: begin
          if (stop) begin
            r_state <= DONE;
            r_led   <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_tick) begin
            if (r_time == TW'(MAXMS - 1)) begin
              r_state   <= DONE;
              r_led     <= 1'b0;
              r_valid   <= 1'b1;
              r_timeout <= 1'b1;
            end
            r_time <= r_time + TW'(1);
          end
        end
        default: begin
          r_state   <= IDLE;
          r_time    <= '0;
          r_led     <= 1'b0;
          r_valid   <= 1'b0;
          r_timeout <= 1'b0;
          r_cheat   <= 1'b0;
        end
      endcase
    end
  end

  assign state   = r_state;
  assign led     = r_led;
  assign time_ms = r_time;
  assign valid   = r_valid;
  assign timeout = r_timeout;
  assign cheat   = r_cheat;

endmodule

// File: doc/reaction_ctrl.md
Name: reaction_ctrl

Overview:
Sequences one reaction-time trial for the display datapath.
- On start: waits a pseudo-random delay, then lights the stimulus LED.
- Counts elapsed milliseconds until the stop button; flags early presses and overruns.
- Timebase is a single-cycle tick enable derived from the system clock, not a divided clock, so all logic stays on clk.
- time_ms feeds the BCD/seven-segment display path.

Parameters:
CLKFREQ, 100_000_000, system clock frequency in Hz
TICKFREQ, 1000, tick rate in Hz (1 ms resolution); TICKDIV = CLKFREQ/TICKFREQ
MAXMS, 9999, timeout count; TW = $clog2(MAXMS+1)
DELAY_MIN, 1000, minimum pre-stimulus delay in ticks
DELAY_RAND_BITS, 12, number of LFSR bits added to DELAY_MIN (0 gives a fixed delay); DW = $clog2(DELAY_MIN + 2**DELAY_RAND_BITS)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse (debounced upstream): begin trial
stop  in  1  one-cycle pulse (debounced upstream): reaction button
led  out  1  stimulus light
time_ms  out  TW  measured/elapsed ms
valid  out  1  result final (DONE)
timeout  out  1  no stop before MAXMS
cheat  out  1  stop pressed before stimulus
state  out  3  current FSM state, for debug/display

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high.
- Reset, including mid-trial: state=IDLE; led, time_ms, valid, timeout, cheat = 0; tick counter = 0; LFSR = 16'hACE1.
- All outputs are registered.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, advances every clk, never all-zero.
- Tick: counter 0..TICKDIV-1; tick=1 while counter==TICKDIV-1. The counter is synchronously cleared on every entry into WAIT or TIMING, so the first tick is sampled TICKDIV edges after entry.
- IDLE (0): led=0.
  - start -> WAIT.
  - On the same edge: delay_cnt = DELAY_MIN + lfsr[DELAY_RAND_BITS-1:0] (width DW); time_ms, valid, timeout, cheat cleared.
  - stop ignored.
- WAIT (1): led=0.
  - stop -> CHEAT. stop has priority over a same-cycle tick.
  - Else on tick: delay_cnt--. The tick where delay_cnt==1 -> TIMING with led=1.
  - start ignored.
- TIMING (2): led=1.
  - stop -> DONE; time_ms frozen. On stop+tick in the same cycle, no increment.
  - Else on tick: time_ms++. If time_ms==MAXMS-1 at that tick -> DONE with time_ms=MAXMS, timeout=1.
  - start ignored.
- DONE (3): led=0, valid=1, time_ms held.
  - start -> WAIT, same loading as from IDLE.
  - stop ignored.
- CHEAT (4): cheat=1, led=0, time_ms=0.
  - start -> WAIT, clearing cheat.
- Encodings 5-7 are illegal and recover to IDLE.
- Latency:
  - led rises at the edge exactly delay*TICKDIV edges after the edge that samples start.
  - time_ms = number of ticks sampled in TIMING before stop.
  - Flags update on the same edge as the state change.
- time_ms never wraps; it saturates at MAXMS via timeout.

Decomposition:
- Package reaction_pkg:
  - state_t enum: IDLE=3'd0, WAIT=3'd1, TIMING=3'd2, DONE=3'd3, CHEAT=3'd4.
  - LFSR_SEED = 16'hACE1.
  - LFSR tap mask constant.
- Sub-module tick_gen (params CLKFREQ, TICKFREQ; ports clk, reset, clr, tick): pulse-enable counter with synchronous clear.
- FSM, LFSR and counters stay in reaction_ctrl.

Test Plan:
- Assert reset for 3 cycles mid-run -> next edge: state=0; led, time_ms, valid, timeout, cheat all 0.
- CLKFREQ=1000, TICKFREQ=100, DELAY_MIN=3, DELAY_RAND_BITS=0; start pulse at edge E0 -> led=1 and state=2 from edge E30; led=0 at every earlier edge.
- Same config; stop pulse sampled 25 ticks after led rise -> state=3, time_ms=25, valid=1, led=0, timeout=0. A later stop leaves time_ms=25.
- stop during WAIT (edge E15) -> state=4, cheat=1, led stays 0, time_ms=0. Then start -> state=1, cheat=0.
- MAXMS=50, no stop -> after 50 ticks in TIMING: state=3, time_ms=50, timeout=1, valid=1. A start then re-enters WAIT with time_ms=0 and timeout=0.
- stop coincident with the 8th tick in TIMING -> time_ms=7, state=3. Reset asserted mid-TIMING -> IDLE with all outputs 0 on the next edge.
